// File: rtl/bp_pkg.sv
// Shared types and counter helpers for the branch predictor.
package bp_pkg;

  // Default geometry of the predictor table.
  localparam int XLEN_DEF     = 32;
  localparam int ENTRIES_DEF  = 64;
  localparam int TAG_BITS_DEF = 8;
  localparam int CTR_BITS_DEF = 2;

  // Counter value written when a taken branch allocates a new entry.
  localparam logic [CTR_BITS_DEF-1:0] CTR_WEAK_TAKEN =
    CTR_BITS_DEF'(32'd1 << (CTR_BITS_DEF - 1));

  // One predictor entry at the default geometry.
  typedef struct packed {
    logic                    valid;
    logic [TAG_BITS_DEF-1:0] tag;
    logic [XLEN_DEF-1:0]     target;
    logic [CTR_BITS_DEF-1:0] ctr;
  } bp_entry_t;

  // Saturating increment; width-agnostic so any counter width can use it.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    logic [31:0] result;
    if (value >= max_value) begin
      result = max_value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

  // Saturating decrement, floor at zero.
  function automatic logic [31:0] sat_dec(input logic [31:0] value);
    logic [31:0] result;
    if (value == 32'd0) begin
      result = 32'd0;
    end else begin
      result = value - 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic of a CTR_BITS-wide saturating up/down counter.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr,
  input  logic                taken,
  output logic [CTR_BITS-1:0] ctr_next
);

  localparam logic [31:0] CTR_MAX = 32'((64'd1 << CTR_BITS) - 64'd1);

  logic [31:0] ctr_wide_s;

  assign ctr_wide_s = 32'(ctr);

  // Step toward taken or not-taken, clamping at both ends.
  always_comb begin
    ctr_next = '0;
    if (taken) begin
      ctr_next = CTR_BITS'(sat_inc(ctr_wide_s, CTR_MAX));
    end else begin
      ctr_next = CTR_BITS'(sat_dec(ctr_wide_s));
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters. Lookup is
// combinational on the fetch PC; resolved branches from ID train the
// table at the next rising edge. Two free-running perf counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int ENTRIES  = ENTRIES_DEF,
  parameter int TAG_BITS = TAG_BITS_DEF,
  parameter int CTR_BITS = CTR_BITS_DEF,
  parameter int INIT_CTR = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] pc_if_i,
  output logic            pred_hit_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_mispred_i,
  output logic [31:0]     perf_updates_o,
  output logic [31:0]     perf_mispred_o
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_LSB  = 2 + IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT_S = CTR_BITS'(INIT_CTR);
  localparam logic [CTR_BITS-1:0] CTR_WEAK_TAKEN_S =
    CTR_BITS'(32'd1 << (CTR_BITS - 1));

  // Table storage, one flop set per entry.
  logic [ENTRIES-1:0]  valid_r;
  logic [TAG_BITS-1:0] tag_r    [ENTRIES];
  logic [XLEN-1:0]     target_r [ENTRIES];
  logic [CTR_BITS-1:0] ctr_r    [ENTRIES];

  logic [31:0] perf_updates_r;
  logic [31:0] perf_mispred_r;

  // Lookup side.
  logic [IDX_BITS-1:0] lk_idx_s;
  logic [TAG_BITS-1:0] lk_tag_s;
  logic                lk_hit_s;
  logic                lk_taken_s;

  // Update side.
  logic [IDX_BITS-1:0] upd_idx_s;
  logic [TAG_BITS-1:0] upd_tag_s;
  logic                upd_hit_s;
  logic [CTR_BITS-1:0] upd_ctr_s;
  logic [CTR_BITS-1:0] upd_ctr_next_s;

  assign lk_idx_s  = pc_if_i[2 +: IDX_BITS];
  assign lk_tag_s  = pc_if_i[TAG_LSB +: TAG_BITS];
  assign upd_idx_s = upd_pc_i[2 +: IDX_BITS];
  assign upd_tag_s = upd_pc_i[TAG_LSB +: TAG_BITS];

  // Low PC bits and bits above the tag do not take part in indexing.
  logic unused_upd_pc_s;
  if (TAG_LSB + TAG_BITS < XLEN) begin : g_upper_unused
    assign unused_upd_pc_s = ^{upd_pc_i[1:0], upd_pc_i[XLEN-1:TAG_LSB+TAG_BITS]};
  end else begin : g_no_upper
    assign unused_upd_pc_s = ^upd_pc_i[1:0];
  end

  // Combinational lookup against the pre-update table contents.
  always_comb begin
    lk_hit_s   = 1'b0;
    lk_taken_s = 1'b0;
    if (valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s)) begin
      lk_hit_s   = 1'b1;
      lk_taken_s = ctr_r[lk_idx_s][CTR_BITS-1];
    end else begin
      lk_hit_s   = 1'b0;
      lk_taken_s = 1'b0;
    end
  end

  // Drive prediction outputs; fall through to the sequential PC when not taken.
  always_comb begin
    pred_hit_o    = lk_hit_s;
    pred_taken_o  = lk_taken_s;
    pred_target_o = pc_if_i + XLEN'(4);
    if (lk_taken_s) begin
      pred_target_o = target_r[lk_idx_s];
    end else begin
      pred_target_o = pc_if_i + XLEN'(4);
    end
  end

  // Hit detection and current counter of the entry being trained.
  always_comb begin
    upd_hit_s = 1'b0;
    upd_ctr_s = ctr_r[upd_idx_s];
    if (valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s)) begin
      upd_hit_s = 1'b1;
    end else begin
      upd_hit_s = 1'b0;
    end
  end

  bp_sat_counter #(
    .CTR_BITS (CTR_BITS)
  ) u_sat_counter (
    .ctr      (upd_ctr_s),
    .taken    (upd_taken_i),
    .ctr_next (upd_ctr_next_s)
  );

  // Valid bits, counters and perf counters: reset clears history, updates train.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r        <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_r[i] <= CTR_INIT_S;
      end
      perf_updates_r <= 32'd0;
      perf_mispred_r <= 32'd0;
    end else if (upd_valid_i) begin
      perf_updates_r <= perf_updates_r + 32'd1;
      if (upd_mispred_i) begin
        perf_mispred_r <= perf_mispred_r + 32'd1;
      end
      if (upd_hit_s) begin
        ctr_r[upd_idx_s] <= upd_ctr_next_s;
      end else if (upd_taken_i) begin
        valid_r[upd_idx_s] <= 1'b1;
        ctr_r[upd_idx_s]   <= CTR_WEAK_TAKEN_S;
      end
    end
  end

  // Tag and target need no reset: a taken update (hit or allocate) rewrites both.
  always_ff @(posedge clk_i) begin
    if (!rst_i && upd_valid_i && upd_taken_i) begin
      tag_r[upd_idx_s]    <= upd_tag_s;
      target_r[upd_idx_s] <= upd_target_i;
    end
  end

  assign perf_updates_o = perf_updates_r;
  assign perf_mispred_o = perf_mispred_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a driver pushes the expected
// lookup/perf response per cycle, a monitor pops and compares.
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] pc_if_i = 32'd0;
  logic        pred_hit_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i = 1'b0;
  logic [31:0] upd_pc_i = 32'd0;
  logic        upd_taken_i = 1'b0;
  logic [31:0] upd_target_i = 32'd0;
  logic        upd_mispred_i = 1'b0;
  logic [31:0] perf_updates_o;
  logic [31:0] perf_mispred_o;

  branch_predictor dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .pc_if_i        (pc_if_i),
    .pred_hit_o     (pred_hit_o),
    .pred_taken_o   (pred_taken_o),
    .pred_target_o  (pred_target_o),
    .upd_valid_i    (upd_valid_i),
    .upd_pc_i       (upd_pc_i),
    .upd_taken_i    (upd_taken_i),
    .upd_target_i   (upd_target_i),
    .upd_mispred_i  (upd_mispred_i),
    .perf_updates_o (perf_updates_o),
    .perf_mispred_o (perf_mispred_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic [31:0] n_upd;
    logic [31:0] n_mis;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a 64-line map from index to (tag, target, confidence).
  bit          m_known = 1'b0;
  bit          m_valid [64];
  int unsigned m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];
  logic [31:0] m_upd = 32'd0;
  logic [31:0] m_mis = 32'd0;

  function automatic int unsigned line_of(input logic [31:0] pc);
    return (pc / 32'd4) % 32'd64;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc / 32'd256) % 32'd256;
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[line_of(pc)] && (m_tag[line_of(pc)] == tag_of(pc));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One bench cycle: drive inputs, record the expected response, advance the model.
  task automatic cyc(input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                     input bit ut, input logic [31:0] utgt, input bit um, input bit r);
    exp_t e;
    int unsigned li;
    @(negedge clk_i);
    pc_if_i       = lpc;
    upd_valid_i   = uv;
    upd_pc_i      = upc;
    upd_taken_i   = ut;
    upd_target_i  = utgt;
    upd_mispred_i = um;
    rst_i         = r;
    if (m_known) begin
      li       = line_of(lpc);
      e.hit    = model_hit(lpc);
      e.taken  = e.hit && (m_ctr[li] >= 2);
      e.target = e.taken ? m_tgt[li] : lpc + 32'd4;
      e.n_upd  = m_upd;
      e.n_mis  = m_mis;
      exp_q.push_back(e);
    end
    if (r) begin
      for (int i = 0; i < 64; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 1;
      end
      m_upd   = 32'd0;
      m_mis   = 32'd0;
      m_known = 1'b1;
    end else if (uv) begin
      li    = line_of(upc);
      m_upd = m_upd + 32'd1;
      if (um) m_mis = m_mis + 32'd1;
      if (model_hit(upc)) begin
        if (ut) begin
          m_ctr[li] = (m_ctr[li] < 3) ? m_ctr[li] + 1 : 3;
          m_tgt[li] = utgt;
        end else begin
          m_ctr[li] = (m_ctr[li] > 0) ? m_ctr[li] - 1 : 0;
        end
      end else if (ut) begin
        m_valid[li] = 1'b1;
        m_tag[li]   = tag_of(upc);
        m_tgt[li]   = utgt;
        m_ctr[li]   = 2;
      end
    end
  endtask

  task automatic look(input logic [31:0] lpc);
    cyc(lpc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic train(input logic [31:0] lpc, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utgt, input bit um);
    cyc(lpc, 1'b1, upc, ut, utgt, um, 1'b0);
  endtask

  // Monitor: compare the DUT against each queued expectation between clock edges.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("hit",    32'(pred_hit_o),   32'(e.hit));
        check("taken",  32'(pred_taken_o), 32'(e.taken));
        check("target", pred_target_o,     e.target);
        check("perf_updates", perf_updates_o, e.n_upd);
        check("perf_mispred", perf_mispred_o, e.n_mis);
      end
    end
  end

  // Driver: directed scenarios followed by randomized traffic.
  initial begin
    logic [31:0] pc;
    logic [31:0] upc;
    int budget;

    cyc(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    look(32'h40);
    look(32'hFFFF_FFFC);

    // First training: same-cycle lookup sees old contents.
    train(32'h40, 32'h40, 1'b1, 32'h80, 1'b1);
    look(32'h40);

    // Saturation at the bottom, then at the top.
    for (int i = 0; i < 3; i++) train(32'h40, 32'h40, 1'b0, 32'h0, 1'b0);
    look(32'h40);
    for (int i = 0; i < 4; i++) train(32'h40, 32'h40, 1'b1, 32'h80, 1'b0);
    look(32'h40);
    for (int i = 0; i < 2; i++) train(32'h40, 32'h40, 1'b0, 32'h0, 1'b0);
    look(32'h40);

    // Aliasing on the same line with a different tag.
    train(32'h40, 32'h40, 1'b1, 32'h80, 1'b0);
    train(32'h40, 32'h40, 1'b1, 32'h80, 1'b0);
    look(32'h140);
    train(32'h140, 32'h140, 1'b1, 32'h200, 1'b0);
    look(32'h140);
    look(32'h40);

    // Misprediction accounting, and an ignored update with garbage fields.
    for (int i = 0; i < 5; i++) train(32'h300, 32'h300 + 32'(i * 4), 1'(i % 2), 32'h1000, 1'(i < 2));
    cyc(32'h300, 1'b0, 32'h140, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    look(32'h140);

    // Reset mid-training with a concurrent update.
    for (int i = 0; i < 4; i++) train(32'h0, 32'h500 + 32'(i * 4), 1'b1, 32'h900 + 32'(i * 4), 1'b0);
    for (int i = 0; i < 4; i++) look(32'h500 + 32'(i * 4));
    cyc(32'h500, 1'b1, 32'h600, 1'b1, 32'h700, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) look(32'h500 + 32'(i * 4));
    look(32'h600);

    // Random traffic over a small PC pool so lines alias and hit often.
    for (int n = 0; n < 1500; n++) begin
      pc  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      upc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      cyc(pc, ($urandom_range(0, 3) != 0), upc, 1'($urandom), $urandom, 1'($urandom),
          ($urandom_range(0, 199) == 0));
    end

    look(32'h40);
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk_i);
      budget--;
    end
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Dynamic branch predictor for the 5-stage RISC-V pipeline. It combines a direct-mapped branch target buffer with per-entry saturating counters. IF looks it up combinationally on the fetch PC to choose the next PC. ID sends resolved BEQ/BNE outcomes back to train it. It replaces "always predict not-taken, flush on taken" and exports performance counters.

Parameters:
XLEN, 32, address/data width
ENTRIES, 64, table depth; power of 2, >= 2; IDX_BITS = clog2(ENTRIES)
TAG_BITS, 8, stored tag width; IDX_BITS + TAG_BITS + 2 <= XLEN
CTR_BITS, 2, saturating counter width, >= 1
INIT_CTR, 1, counter value after reset (weakly not-taken for CTR_BITS=2)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
pc_if_i  in  XLEN  fetch PC for lookup
pred_hit_o  out  1  valid entry with matching tag for pc_if_i
pred_taken_o  out  1  predict taken
pred_target_o  out  XLEN  predicted next PC
upd_valid_i  in  1  resolved conditional branch in ID this cycle
upd_pc_i  in  XLEN  PC of resolved branch
upd_taken_i  in  1  actual outcome
upd_target_i  in  XLEN  actual branch target (pc + imm)
upd_mispred_i  in  1  ID found that the prediction differed from the outcome
perf_updates_o  out  32  count of accepted updates
perf_mispred_o  out  32  count of accepted mispredicted updates

Behaviour:
- Address split: idx = pc[2 +: IDX_BITS]; tag = pc[2+IDX_BITS +: TAG_BITS]. pc[1:0] is ignored.
- Entry contents: valid, tag[TAG_BITS], target[XLEN], ctr[CTR_BITS]. Table is held in flops, not RAM.
- Lookup is purely combinational, zero latency:
  - hit = valid[idx] & (tag[idx] == tag(pc_if_i)).
  - pred_taken_o = hit & ctr[idx][CTR_BITS-1].
  - pred_target_o = target[idx] if pred_taken_o, else pc_if_i + 4 (wraps mod 2^XLEN).
- Update takes effect at the next rising edge when upd_valid_i=1 and rst_i=0:
  - Hit, taken: ctr = min(ctr+1, 2^CTR_BITS-1); target overwritten with upd_target_i.
  - Hit, not-taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate and replace. valid=1, tag written, target written, ctr = 2^(CTR_BITS-1) (weakly taken).
  - Miss, not-taken: no table change.
- Lookup and update in the same cycle, even at the same idx: lookup returns the pre-update contents. There is no write-through bypass; the new contents are visible next cycle.
- Only one update per cycle. The caller must not assert upd_valid_i for a flushed or NoOP'd instruction; the block does not filter this.
- Perf counters:
  - perf_updates_o increments on each accepted update.
  - perf_mispred_o increments when an accepted update also has upd_mispred_i=1.
  - Both wrap mod 2^32.
- Reset, when rst_i is high at a clock edge:
  - Every valid=0 and every ctr=INIT_CTR. Tag and target are don't-care.
  - Both perf counters = 0.
  - Any update in that cycle is discarded.
  - Outputs after reset: pred_hit_o=0, pred_taken_o=0, pred_target_o=pc_if_i+4.
  - Reset mid-training loses all history; no partial state survives.
- Unknown or X on upd_* while upd_valid_i=0 must not change state.

Decomposition:
- Shared package bp_pkg: counter helpers sat_inc/sat_dec, constant CTR_WEAK_TAKEN = 2^(CTR_BITS-1), and an entry struct typedef {valid, tag, target, ctr} parameterised via localparams.
- Natural sub-module: bp_sat_counter (CTR_BITS-wide saturating up/down next-state logic), instantiated per entry or as a shared function.
- Perf counters stay inline.

Test Plan:
- Reset, then look up pc 0x40 -> hit=0, taken=0, target=0x44; perf counters both 0.
- Update pc 0x40, taken, target 0x80 -> same-cycle lookup of 0x40 still gives taken=0; next cycle hit=1, taken=1, target=0x80, perf_updates=1.
- Counter saturation:
  - From ctr=2, apply three not-taken updates at 0x40 -> taken=0 after the first; ctr stays 0 after the third.
  - Then apply four taken updates -> taken=1 after the second; ctr saturates at 3.
- Aliasing (ENTRIES=64): train 0x40 taken, then look up 0x140 -> hit=0, target=0x144. Then update 0x140 taken, target 0x200 -> 0x140 hits with target 0x200; 0x40 now misses.
- Misprediction count: 5 updates with upd_mispred_i high on 2 of them -> perf_updates=5, perf_mispred=2. An update with upd_valid_i=0 and upd_mispred_i=1 -> no change.
- Reset mid-training: train 4 PCs, then hold rst_i high for one cycle with upd_valid_i=1 -> all 4 lookups miss, perf counters 0, and the concurrent update is not applied.
